// File: rtl/hc_csr_bank.sv
// MMIO CSR bank for HardCloud accelerators: DSM base, control FSM, buffer descriptors,
// and tid-tagged read responses one cycle after each MMIO read request.
module hc_csr_bank #(
  parameter int NUM_BUFFERS = 2,
  parameter int ADDR_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mmio_wr_valid,
  input  logic                     mmio_rd_valid,
  input  logic [ADDR_W-1:0]        mmio_addr,
  input  logic [8:0]               mmio_tid,
  input  logic [63:0]              mmio_wr_data,
  output logic                     rd_rsp_valid,
  output logic [8:0]               rd_rsp_tid,
  output logic [63:0]              rd_rsp_data,
  input  logic                     accel_done,
  output logic                     accel_reset,
  output logic                     start_pulse,
  output logic                     stop_pulse,
  output logic [63:0]              dsm_base,
  output logic [64*NUM_BUFFERS-1:0] buf_addr,
  output logic [32*NUM_BUFFERS-1:0] buf_size
);
  localparam int IDX_W = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h42);
  localparam logic [ADDR_W-1:0] A_DSM    = ADDR_W'(32'h44);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h46);
  localparam logic [ADDR_W-1:0] A_BUF0   = ADDR_W'(32'h48);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              accel_reset_q;
  logic              start_pulse_q, start_pulse_d;
  logic              stop_pulse_q, stop_pulse_d;
  logic [63:0]       dsm_q, dsm_d;
  logic [63:0]       buf_addr_q [NUM_BUFFERS];
  logic [63:0]       buf_addr_d [NUM_BUFFERS];
  logic [31:0]       buf_size_q [NUM_BUFFERS];
  logic [31:0]       buf_size_d [NUM_BUFFERS];
  logic              rd_rsp_valid_q;
  logic [8:0]        rd_rsp_tid_q;
  logic [63:0]       rd_rsp_data_q;
  logic [63:0]       rd_data_s;
  logic [ADDR_W-1:0] buf_off_s;
  logic [IDX_W-1:0]  buf_idx_s;
  logic              buf_hit_s;
  logic              wr_ok_s;
  logic              ctrl_wr_s;
  logic              ctrl_taken_s;
  logic [31:0]       cmd_s;

  // Buffer window decode: every 4 dwords hold one descriptor, odd dwords are holes
  always_comb begin
    buf_off_s = mmio_addr - A_BUF0;
    buf_idx_s = buf_off_s[IDX_W+1:2];
    buf_hit_s = (mmio_addr >= A_BUF0) && !buf_off_s[0] &&
                ((buf_off_s >> 2'd2) < ADDR_W'(NUM_BUFFERS));
    wr_ok_s   = mmio_wr_valid && (state_q != S_RUN);
    ctrl_wr_s = mmio_wr_valid && (mmio_addr == A_CTRL);
    cmd_s     = mmio_wr_data[31:0];
  end

  // Register file next-state; DSM and descriptors are frozen while running
  always_comb begin
    if (wr_ok_s && (mmio_addr == A_DSM)) begin
      dsm_d = mmio_wr_data;
    end else begin
      dsm_d = dsm_q;
    end
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      buf_addr_d[i] = buf_addr_q[i];
      buf_size_d[i] = buf_size_q[i];
      if (wr_ok_s && buf_hit_s && (buf_idx_s == IDX_W'(i))) begin
        if (buf_off_s[1]) begin
          buf_size_d[i] = mmio_wr_data[31:0];
        end else begin
          buf_addr_d[i] = mmio_wr_data;
        end
      end else begin
        buf_addr_d[i] = buf_addr_q[i];
      end
    end
  end

  // Control FSM: a legal CONTROL command takes priority over accel_done
  always_comb begin
    state_d       = state_q;
    start_pulse_d = 1'b0;
    stop_pulse_d  = 1'b0;
    ctrl_taken_s  = 1'b0;
    if (ctrl_wr_s) begin
      case (cmd_s)
        32'h0: begin
          state_d      = S_RESET;
          ctrl_taken_s = 1'b1;
        end
        32'h1: begin
          if ((state_q == S_RESET) || (state_q == S_DONE)) begin
            state_d      = S_IDLE;
            ctrl_taken_s = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        32'h3: begin
          if (state_q == S_IDLE) begin
            state_d       = S_RUN;
            start_pulse_d = 1'b1;
            ctrl_taken_s  = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        32'h7: begin
          if (state_q == S_RUN) begin
            state_d      = S_IDLE;
            stop_pulse_d = 1'b1;
            ctrl_taken_s = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = state_q;
      endcase
    end else begin
      state_d = state_q;
    end
    if ((state_q == S_RUN) && accel_done && !ctrl_taken_s) begin
      state_d = S_DONE;
    end else begin
      start_pulse_d = start_pulse_d;
    end
  end

  // Read mux over the current (pre-write) register contents
  always_comb begin
    rd_data_s = 64'd0;
    if (mmio_addr == A_STATUS) begin
      rd_data_s = {62'd0, state_q};
    end else if (mmio_addr == A_DSM) begin
      rd_data_s = dsm_q;
    end else if (buf_hit_s) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (buf_idx_s == IDX_W'(i)) begin
          rd_data_s = buf_off_s[1] ? {32'd0, buf_size_q[i]} : buf_addr_q[i];
        end else begin
          rd_data_s = rd_data_s;
        end
      end
    end else begin
      rd_data_s = 64'd0;
    end
  end

  // State, registers and response pipeline
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_RESET;
      accel_reset_q  <= 1'b1;
      start_pulse_q  <= 1'b0;
      stop_pulse_q   <= 1'b0;
      dsm_q          <= 64'd0;
      rd_rsp_valid_q <= 1'b0;
      rd_rsp_tid_q   <= 9'd0;
      rd_rsp_data_q  <= 64'd0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_addr_q[i] <= 64'd0;
        buf_size_q[i] <= 32'd0;
      end
    end else begin
      state_q        <= state_d;
      accel_reset_q  <= (state_d == S_RESET);
      start_pulse_q  <= start_pulse_d;
      stop_pulse_q   <= stop_pulse_d;
      dsm_q          <= dsm_d;
      rd_rsp_valid_q <= mmio_rd_valid;
      rd_rsp_tid_q   <= mmio_tid;
      rd_rsp_data_q  <= rd_data_s;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        buf_addr_q[i] <= buf_addr_d[i];
        buf_size_q[i] <= buf_size_d[i];
      end
    end
  end

  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_rsp_tid   = rd_rsp_tid_q;
  assign rd_rsp_data  = rd_rsp_data_q;
  assign accel_reset  = accel_reset_q;
  assign start_pulse  = start_pulse_q;
  assign stop_pulse   = stop_pulse_q;
  assign dsm_base     = dsm_q;

  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_buf_out
    assign buf_addr[64*g +: 64] = buf_addr_q[g];
    assign buf_size[32*g +: 32] = buf_size_q[g];
  end
endmodule
